image_sender: RTL

Transmit-side counterpart of the image upload path: reads a 784-byte image from image RAM and streams it as a framed byte sequence to `uart_tx` for host readback and debug. The frame is `0xAA 0x55`, then pixel bytes 0..783 in address order, then `0x66 0xBB`. It sits between the image RAM read port and the UART transmitter, sharing the RAM with the upload path and the inference engine.

---
 rtl/image_proto_pkg.sv | 20 ++
 rtl/image_tx_checksum.sv | 35 +++
 rtl/image_sender.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/image_proto_pkg.sv
// image_proto_pkg: framing constants and sender state encoding shared by the
// image upload path, uart_router and image_sender.
package image_proto_pkg;

  localparam int unsigned IMG_SIZE = 784;

  localparam logic [7:0] IMG_START1 = 8'hAA;
  localparam logic [7:0] IMG_START2 = 8'h55;
  localparam logic [7:0] IMG_END1   = 8'h66;
  localparam logic [7:0] IMG_END2   = 8'hBB;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_ACK,
    ST_WAIT_FREE,
    ST_FINISH
  } sender_state_e;

endpackage

// File: rtl/image_tx_checksum.sv
// image_tx_checksum: byte-wide XOR accumulator with synchronous clear and enable.
// Only compiled when IMAGE_SENDER_CHECKSUM_EN is defined, matching its sole user.
`ifdef IMAGE_SENDER_CHECKSUM_EN
module image_tx_checksum (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic [7:0] data_i,
  output logic [7:0] sum_o
);

  logic [7:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clr_i) begin
      sum_d = '0;
    end else if (en_i) begin
      sum_d = sum_q ^ data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule
`endif

// File: rtl/image_sender.sv
// image_sender: streams AA 55, IMG_SIZE pixel bytes from image RAM, then 66 BB to uart_tx.
// Define IMAGE_SENDER_CHECKSUM_EN to insert an XOR-of-pixels byte before the trailer.
module image_sender
  import image_proto_pkg::*;
#(
  parameter int unsigned IMG_SIZE = image_proto_pkg::IMG_SIZE,
  parameter int unsigned ADDR_W   = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              image_valid,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic              busy,
  output logic              done
);

`ifdef IMAGE_SENDER_CHECKSUM_EN
  localparam int unsigned FRAME_LEN = IMG_SIZE + 5;
`else
  localparam int unsigned FRAME_LEN = IMG_SIZE + 4;
`endif
  localparam int unsigned IDX_W = $clog2(FRAME_LEN);

  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(FRAME_LEN - 1);
  localparam logic [IDX_W-1:0] END1_IDX     = IDX_W'(FRAME_LEN - 2);
  localparam logic [IDX_W-1:0] PIX_LAST_IDX = IDX_W'(IMG_SIZE + 1);
`ifdef IMAGE_SENDER_CHECKSUM_EN
  localparam logic [IDX_W-1:0] CSUM_IDX     = IDX_W'(IMG_SIZE + 2);
`endif

  sender_state_e    state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic [7:0]       pix_q;
  logic             rd_pend_q;
  logic             rd_issued_q;

  logic [IDX_W-1:0] nidx;
  logic             next_is_pix;
  logic [7:0]       pix_src;
  logic [7:0]       next_byte;

  assign nidx        = idx_q + IDX_W'(1);
  assign next_is_pix = (nidx >= IDX_W'(2)) && (nidx <= PIX_LAST_IDX);

  // A WAIT_FREE that ends on the cycle the prefetch data arrives takes it straight off the RAM port.
  assign pix_src = rd_pend_q ? rd_data : pix_q;

`ifdef IMAGE_SENDER_CHECKSUM_EN
  logic [7:0] csum;

  image_tx_checksum u_checksum (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i ((state_q == ST_IDLE) && (state_d == ST_SEND)),
    .en_i  (rd_pend_q),
    .data_i(rd_data),
    .sum_o (csum)
  );
`endif

  always_comb begin
    next_byte = IMG_END2;
    if (nidx == IDX_W'(1)) begin
      next_byte = IMG_START2;
    end else if (next_is_pix) begin
      next_byte = pix_src;
`ifdef IMAGE_SENDER_CHECKSUM_EN
    end else if (nidx == CSUM_IDX) begin
      next_byte = csum;
`endif
    end else if (nidx == END1_IDX) begin
      next_byte = IMG_END1;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    tx_data_d = tx_data_q;
    case (state_q)
      ST_IDLE: begin
        if (start && image_valid && !tx_busy) begin
          state_d   = ST_SEND;
          idx_d     = '0;
          tx_data_d = IMG_START1;
        end
      end
      ST_SEND:     state_d = ST_WAIT_ACK;
      ST_WAIT_ACK: if (tx_busy) state_d = ST_WAIT_FREE;
      ST_WAIT_FREE: begin
        if (!tx_busy) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_FINISH;
          end else begin
            state_d   = ST_SEND;
            idx_d     = nidx;
            tx_data_d = next_byte;
          end
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign rd_en    = (state_q == ST_WAIT_ACK) && next_is_pix && !rd_issued_q;
  assign rd_addr  = rd_en ? ADDR_W'(idx_q - IDX_W'(1)) : '0;
  assign tx_start = (state_q == ST_SEND);
  assign tx_data  = tx_data_q;
  assign busy     = (state_q == ST_SEND) || (state_q == ST_WAIT_ACK) || (state_q == ST_WAIT_FREE);
  assign done     = (state_q == ST_FINISH);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      tx_data_q   <= '0;
      pix_q       <= '0;
      rd_pend_q   <= 1'b0;
      rd_issued_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      tx_data_q   <= tx_data_d;
      rd_pend_q   <= rd_en;
      if (rd_pend_q) begin
        pix_q <= rd_data;
      end
      if (state_q == ST_SEND) begin
        rd_issued_q <= 1'b0;
      end else if (rd_en) begin
        rd_issued_q <= 1'b1;
      end
    end
  end

endmodule
